// File: rtl/id_ex_issue_if.sv
// Bundle of the ID/EX issue-stage signals: ID request side, EX/MEM and MEM/WB
// writeback snoop, downstream handshake and the ALU-facing outputs.
interface id_ex_issue_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] id_rs_addr;
    logic [RW-1:0] id_rt_addr;
    logic [RW-1:0] id_dest_addr;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [15:0]   id_imm;
    logic [4:0]    id_shamt;
    logic [5:0]    id_alufn;
    logic [1:0]    id_alusrc;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          exm_reg_write;
    logic [RW-1:0] exm_dest_addr;
    logic [DW-1:0] exm_result;
    logic          mwb_reg_write;
    logic [RW-1:0] mwb_dest_addr;
    logic [DW-1:0] mwb_result;
    logic          out_ready;
    logic          ex_valid;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [5:0]    alu_alufn;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_dest_addr;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          load_use_stall;

    modport master (
        output flush, in_valid,
        output id_rs_addr, id_rt_addr, id_dest_addr, id_rs_data, id_rt_data,
        output id_imm, id_shamt, id_alufn, id_alusrc,
        output id_reg_write, id_mem_read, id_mem_write,
        output exm_reg_write, exm_dest_addr, exm_result,
        output mwb_reg_write, mwb_dest_addr, mwb_result,
        output out_ready,
        input  in_ready, ex_valid, alu_a, alu_b, alu_alufn, ex_store_data,
        input  ex_dest_addr, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );

    modport slave (
        input  flush, in_valid,
        input  id_rs_addr, id_rt_addr, id_dest_addr, id_rs_data, id_rt_data,
        input  id_imm, id_shamt, id_alufn, id_alusrc,
        input  id_reg_write, id_mem_read, id_mem_write,
        input  exm_reg_write, exm_dest_addr, exm_result,
        input  mwb_reg_write, mwb_dest_addr, mwb_result,
        input  out_ready,
        output in_ready, ex_valid, alu_a, alu_b, alu_alufn, ex_store_data,
        output ex_dest_addr, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );
endinterface

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register feeding the ALU: single held entry with EX/MEM and
// MEM/WB operand forwarding, load-use stall detection and flush.
module id_ex_issue #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    id_ex_issue_if.slave    bus
);

    logic          r_valid;
    logic [RW-1:0] r_rs_addr;
    logic [RW-1:0] r_rt_addr;
    logic [RW-1:0] r_dest_addr;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [15:0]   r_imm;
    logic [4:0]    r_shamt;
    logic [1:0]    r_alusrc;
    logic [5:0]    r_alufn;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;

    logic          w_fire_out;
    logic          w_slot_free;
    logic          w_rs_hit;
    logic          w_rt_hit;
    logic          w_hazard;
    logic          w_accept;
    logic          w_hold;
    logic          w_rs_refresh;
    logic          w_rt_refresh;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;
    logic [DW-1:0] w_alu_b;

    // $0 is hard-wired zero; EX/MEM is the younger producer so it wins over MEM/WB.
    function automatic logic [DW-1:0] forward(
        input logic [RW-1:0] addr,
        input logic [DW-1:0] stored,
        input logic          exm_we,
        input logic [RW-1:0] exm_addr,
        input logic [DW-1:0] exm_val,
        input logic          mwb_we,
        input logic [RW-1:0] mwb_addr,
        input logic [DW-1:0] mwb_val
    );
        logic [DW-1:0] v;
        if (addr == '0)
            v = '0;
        else if (exm_we && (exm_addr == addr))
            v = exm_val;
        else if (mwb_we && (mwb_addr == addr))
            v = mwb_val;
        else
            v = stored;
        return v;
    endfunction

    assign w_fire_out  = r_valid & bus.out_ready;
    assign w_slot_free = ~r_valid | bus.out_ready;
    assign w_hold      = r_valid & ~bus.out_ready;

    // rt only matters for the hazard when it is actually read as an operand or store data.
    assign w_rs_hit = (r_dest_addr == bus.id_rs_addr);
    assign w_rt_hit = (r_dest_addr == bus.id_rt_addr) &
                      ((bus.id_alusrc == 2'd0) | bus.id_mem_write);
    assign w_hazard = r_valid & r_mem_read & (r_dest_addr != '0) & bus.in_valid &
                      (w_rs_hit | w_rt_hit);

    assign bus.in_ready       = w_slot_free & ~w_hazard & ~bus.flush;
    assign bus.load_use_stall = w_hazard;
    assign w_accept           = bus.in_valid & bus.in_ready;

    // While stalled downstream, MEM/WB may retire the value we were forwarding; capture it.
    assign w_rs_refresh = w_hold & bus.mwb_reg_write & (r_rs_addr != '0) &
                          (bus.mwb_dest_addr == r_rs_addr);
    assign w_rt_refresh = w_hold & bus.mwb_reg_write & (r_rt_addr != '0) &
                          (bus.mwb_dest_addr == r_rt_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (w_fire_out) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_dest_addr <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_shamt     <= '0;
            r_alusrc    <= '0;
            r_alufn     <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_accept) begin
            r_rs_addr   <= bus.id_rs_addr;
            r_rt_addr   <= bus.id_rt_addr;
            r_dest_addr <= bus.id_dest_addr;
            r_rs_data   <= bus.id_rs_data;
            r_rt_data   <= bus.id_rt_data;
            r_imm       <= bus.id_imm;
            r_shamt     <= bus.id_shamt;
            r_alusrc    <= bus.id_alusrc;
            r_alufn     <= bus.id_alufn;
            r_reg_write <= bus.id_reg_write;
            r_mem_read  <= bus.id_mem_read;
            r_mem_write <= bus.id_mem_write;
        end else begin
            if (w_rs_refresh)
                r_rs_data <= bus.mwb_result;
            if (w_rt_refresh)
                r_rt_data <= bus.mwb_result;
        end
    end

    assign w_fwd_rs = forward(r_rs_addr, r_rs_data,
                              bus.exm_reg_write, bus.exm_dest_addr, bus.exm_result,
                              bus.mwb_reg_write, bus.mwb_dest_addr, bus.mwb_result);
    assign w_fwd_rt = forward(r_rt_addr, r_rt_data,
                              bus.exm_reg_write, bus.exm_dest_addr, bus.exm_result,
                              bus.mwb_reg_write, bus.mwb_dest_addr, bus.mwb_result);

    always_comb begin
        w_alu_b = w_fwd_rt;
        case (r_alusrc)
            2'd1:    w_alu_b = {{(DW-16){r_imm[15]}}, r_imm};
            2'd2:    w_alu_b = {{(DW-16){1'b0}}, r_imm};
            2'd3:    w_alu_b = {{(DW-5){1'b0}}, r_shamt};
            default: w_alu_b = w_fwd_rt;
        endcase
    end

    assign bus.ex_valid      = r_valid;
    assign bus.alu_a         = w_fwd_rs;
    assign bus.alu_b         = w_alu_b;
    assign bus.alu_alufn     = r_alufn;
    assign bus.ex_store_data = w_fwd_rt;
    assign bus.ex_dest_addr  = r_dest_addr;
    assign bus.ex_reg_write  = r_valid & r_reg_write;
    assign bus.ex_mem_read   = r_valid & r_mem_read;
    assign bus.ex_mem_write  = r_valid & r_mem_write;

endmodule

// File: tb/tb_id_ex_issue.sv
// Scoreboard bench for id_ex_issue: directed instructions push expected ALU
// presentations; a negedge monitor pops and compares whenever an entry fires.
module tb_id_ex_issue;

    logic clk = 1'b0;
    logic rst_n;

    id_ex_issue_if #(.DW(32), .RW(5)) bus ();

    id_ex_issue #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [5:0]  fn;
        logic [7:0]  ctl;
    } exp_t;

    typedef struct {
        logic [4:0]  rs;
        logic [31:0] rsd;
        logic [4:0]  rt;
        logic [31:0] rtd;
        logic        exmRw;
        logic [4:0]  exmDest;
        logic        mwbRw;
        logic [4:0]  mwbDest;
        logic [31:0] expA;
        logic [31:0] expB;
    } fwd_vec_t;

    typedef struct {
        logic [1:0]  src;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [5:0]  fn;
        logic [31:0] expB;
    } src_vec_t;

    exp_t sbq[$];
    exp_t monE;
    int   nChecks = 0;
    int   nPass   = 0;

    fwd_vec_t fwdVec[5] = '{
        '{5'd3, 32'hAA, 5'd2, 32'h07, 1'b1, 5'd3, 1'b1, 5'd3, 32'h11, 32'h07},
        '{5'd3, 32'hAA, 5'd2, 32'h07, 1'b0, 5'd3, 1'b1, 5'd3, 32'h22, 32'h07},
        '{5'd0, 32'hAA, 5'd2, 32'h07, 1'b1, 5'd0, 1'b1, 5'd0, 32'h00, 32'h07},
        '{5'd3, 32'hAA, 5'd5, 32'hBB, 1'b1, 5'd9, 1'b1, 5'd5, 32'hAA, 32'h22},
        '{5'd4, 32'hCC, 5'd4, 32'hDD, 1'b1, 5'd4, 1'b1, 5'd4, 32'h11, 32'h11}
    };

    src_vec_t srcVec[4] = '{
        '{2'd1, 16'hFFF0, 5'd0, 6'b000001, 32'hFFFF_FFF0},
        '{2'd2, 16'hFFF0, 5'd0, 6'b000110, 32'h0000_FFF0},
        '{2'd3, 16'hFFF0, 5'd3, 6'b001000, 32'h0000_0003},
        '{2'd0, 16'hFFF0, 5'd3, 6'b111111, 32'h0000_0007}
    };

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act === req)
            nPass++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    task automatic pushExp(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] sd, input logic [5:0] fn, input logic [4:0] dest,
                           input logic rw, input logic mr, input logic mw);
        exp_t e;
        e.name = name;
        e.a    = a;
        e.b    = b;
        e.sd   = sd;
        e.fn   = fn;
        e.ctl  = {dest, rw, mr, mw};
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic [4:0] rs, input logic [31:0] rsd,
                                 input logic [4:0] rt, input logic [31:0] rtd,
                                 input logic [4:0] dest, input logic [15:0] imm,
                                 input logic [4:0] shamt, input logic [5:0] fn,
                                 input logic [1:0] src, input logic rw,
                                 input logic mr, input logic mw);
        bus.id_rs_addr   = rs;
        bus.id_rs_data   = rsd;
        bus.id_rt_addr   = rt;
        bus.id_rt_data   = rtd;
        bus.id_dest_addr = dest;
        bus.id_imm       = imm;
        bus.id_shamt     = shamt;
        bus.id_alufn     = fn;
        bus.id_alusrc    = src;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
        bus.in_valid     = 1'b1;
    endtask

    task automatic setFwd(input logic exmRw, input logic [4:0] exmDest, input logic [31:0] exmRes,
                          input logic mwbRw, input logic [4:0] mwbDest, input logic [31:0] mwbRes);
        bus.exm_reg_write = exmRw;
        bus.exm_dest_addr = exmDest;
        bus.exm_result    = exmRes;
        bus.mwb_reg_write = mwbRw;
        bus.mwb_dest_addr = mwbDest;
        bus.mwb_result    = mwbRes;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the stage hands an entry downstream, it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ex_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpected_output: alu_a=0x%08h with empty scoreboard, required none", bus.alu_a);
            end else begin
                monE = sbq.pop_front();
                checkOutput({monE.name, ".alu_a"}, bus.alu_a, monE.a);
                checkOutput({monE.name, ".alu_b"}, bus.alu_b, monE.b);
                checkOutput({monE.name, ".store"}, bus.ex_store_data, monE.sd);
                checkOutput({monE.name, ".alufn"}, {26'b0, bus.alu_alufn}, {26'b0, monE.fn});
                checkOutput({monE.name, ".ctl"},
                            {24'b0, bus.ex_dest_addr, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
                            {24'b0, monE.ctl});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        applyStimulus(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 16'h0, 5'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        #12;
        checkOutput("rst_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        checkOutput("rst_alu_a", bus.alu_a, 32'h0);
        checkOutput("rst_alu_b", bus.alu_b, 32'h0);
        checkOutput("rst_alufn", {26'b0, bus.alu_alufn}, 32'h0);
        checkOutput("rst_ctl", {24'b0, bus.ex_dest_addr, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        // Plain add, no forwarding, one-cycle latency.
        pushExp("add", 32'd5, 32'd7, 32'd7, 6'b000000, 5'd8, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd1, 32'd5, 5'd2, 32'd7, 5'd8, 16'h0, 5'd0, 6'b000000, 2'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("idle_in_ready", {31'b0, bus.in_ready}, 32'h1);
        nextCycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("latency_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
        nextCycle();

        // Forwarding priority and $0 handling.
        for (int i = 0; i < 5; i++) begin
            pushExp($sformatf("fwd%0d", i), fwdVec[i].expA, fwdVec[i].expB, fwdVec[i].expB,
                    6'b000000, 5'd10, 1'b1, 1'b0, 1'b0);
            applyStimulus(fwdVec[i].rs, fwdVec[i].rsd, fwdVec[i].rt, fwdVec[i].rtd, 5'd10,
                          16'h0, 5'd0, 6'b000000, 2'd0, 1'b1, 1'b0, 1'b0);
            nextCycle();
            bus.in_valid = 1'b0;
            setFwd(fwdVec[i].exmRw, fwdVec[i].exmDest, 32'h11, fwdVec[i].mwbRw, fwdVec[i].mwbDest, 32'h22);
            @(negedge clk);
            nextCycle();
            setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        end

        // Operand b selection and alufn pass-through, issued back to back.
        for (int i = 0; i < 4; i++) begin
            pushExp($sformatf("src%0d", i), 32'h1234, srcVec[i].expB, 32'd7, srcVec[i].fn,
                    5'd11, 1'b1, 1'b0, 1'b0);
            applyStimulus(5'd1, 32'h1234, 5'd2, 32'd7, 5'd11, srcVec[i].imm, srcVec[i].shamt,
                          srcVec[i].fn, srcVec[i].src, 1'b1, 1'b0, 1'b0);
            nextCycle();
        end
        bus.in_valid = 1'b0;
        nextCycle();

        // Load-use: lw $4 then a reader of $4 stalls exactly one cycle.
        pushExp("lw", 32'h100, 32'h10, 32'h0, 6'b000000, 5'd4, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'd1, 32'h100, 5'd0, 32'h0, 5'd4, 16'h0010, 5'd0, 6'b000000, 2'd1, 1'b1, 1'b1, 1'b0);
        nextCycle();
        pushExp("use", 32'h55, 32'd7, 32'd7, 6'b000000, 5'd9, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd4, 32'h7, 5'd2, 32'd7, 5'd9, 16'h0, 5'd0, 6'b000000, 2'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lu_stall", {31'b0, bus.load_use_stall}, 32'h1);
        checkOutput("lu_in_ready", {31'b0, bus.in_ready}, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("lu_bubble_valid", {31'b0, bus.ex_valid}, 32'h0);
        checkOutput("lu_bubble_rw", {31'b0, bus.ex_reg_write}, 32'h0);
        checkOutput("lu_stall_clear", {31'b0, bus.load_use_stall}, 32'h0);
        checkOutput("lu_in_ready_back", {31'b0, bus.in_ready}, 32'h1);
        nextCycle();
        bus.in_valid = 1'b0;
        setFwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h55);
        @(negedge clk);
        nextCycle();
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Held entry picks up a MEM/WB write that retires during the hold.
        pushExp("hold", 32'h99, 32'd7, 32'd7, 6'b000000, 5'd12, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd6, 32'h10, 5'd2, 32'd7, 5'd12, 16'h0, 5'd0, 6'b000000, 2'd0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        setFwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h99);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_alu_a%0d", i), bus.alu_a, 32'h99);
            nextCycle();
        end
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("hold_after_wb", bus.alu_a, 32'h99);
        checkOutput("hold_valid", {31'b0, bus.ex_valid}, 32'h1);
        nextCycle();
        bus.out_ready = 1'b1;
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        checkOutput("hold_drained", {31'b0, bus.ex_valid}, 32'h0);
        nextCycle();

        // Flush kills the held entry and refuses the instruction presented with it.
        bus.out_ready = 1'b0;
        applyStimulus(5'd1, 32'd5, 5'd2, 32'd7, 5'd13, 16'h0, 5'd0, 6'b000010, 2'd0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd1, 32'h21, 5'd2, 32'h3, 5'd14, 16'h0, 5'd0, 6'b000101, 2'd0, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", {31'b0, bus.in_ready}, 32'h0);
        checkOutput("flush_pre_valid", {31'b0, bus.ex_valid}, 32'h1);
        nextCycle();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        pushExp("after_flush", 32'h21, 32'h3, 32'h3, 6'b000101, 5'd14, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush_kill", {31'b0, bus.ex_valid}, 32'h0);
        checkOutput("flush_in_ready_back", {31'b0, bus.in_ready}, 32'h1);
        nextCycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        nextCycle();

        // Reset asserted while a load-use stall is in progress.
        bus.out_ready = 1'b0;
        applyStimulus(5'd1, 32'd5, 5'd2, 32'd7, 5'd15, 16'h0, 5'd0, 6'b000010, 2'd0, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(5'd15, 32'h0, 5'd2, 32'd7, 5'd16, 16'h0, 5'd0, 6'b000000, 2'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall_before_reset", {31'b0, bus.load_use_stall}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        checkOutput("midrst_mem_read", {31'b0, bus.ex_mem_read}, 32'h0);
        checkOutput("midrst_alufn", {26'b0, bus.alu_alufn}, 32'h0);
        checkOutput("midrst_stall", {31'b0, bus.load_use_stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) nextCycle();
        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
